// File: rtl/lv8_pipe_pkg.sv
// Shared definitions for the LEGv8 pipeline sequencing controller:
// FSM encoding, register-file constants and the per-cycle control bundle.
package lv8_pipe_pkg;

   localparam int REG_W = 5;
   localparam int XZR   = 31;

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_MEM_WAIT = 2'd1;
   localparam logic [1:0] ST_HALTED   = 2'd2;
   localparam logic [1:0] ST_STEP     = 2'd3;

   typedef struct packed {
      logic pc_write;
      logic ifid_write;
      logic idex_write;
      logic exmem_write;
      logic memwb_write;
      logic idex_bubble;
      logic flush_ifid;
      logic flush_idex;
      logic flush_exmem;
      logic pc_sel_target;
   } ctl_t;

   localparam ctl_t CTL_FREEZE   = ctl_t'(10'b00000_0_000_0);
   localparam ctl_t CTL_GO       = ctl_t'(10'b11111_0_000_0);
   localparam ctl_t CTL_BUBBLE   = ctl_t'(10'b00111_1_000_0);
   localparam ctl_t CTL_REDIRECT = ctl_t'(10'b11111_0_111_1);

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose destination feeds the instruction in ID.
// XZR is never a real dependency, so it is excluded up front.
module hazard_detect
   import lv8_pipe_pkg::*;
#(
   parameter int REG_W = lv8_pipe_pkg::REG_W,
   parameter int XZR   = lv8_pipe_pkg::XZR
) (
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rn,
   input  logic [REG_W-1:0] id_rm,
   input  logic             id_uses_rm,
   input  logic             ex_valid,
   input  logic             ex_memread,
   input  logic [REG_W-1:0] ex_rd,
   output logic             load_use
);

   logic rn_hit, rm_hit;

   assign rn_hit   = (ex_rd == id_rn);
   assign rm_hit   = id_uses_rm & (ex_rd == id_rm);
   assign load_use = id_valid & ex_valid & ex_memread &
                     (ex_rd != REG_W'(XZR)) & (rn_hit | rm_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// LEGv8 5-stage sequencing controller: load-use bubbles, MEM-resolved redirects,
// data-memory wait freezes, debug halt/step, and saturating stall/flush counters.
module pipeline_ctrl
   import lv8_pipe_pkg::*;
#(
   parameter int CNT_W = 32,
   parameter int REG_W = lv8_pipe_pkg::REG_W,
   parameter int XZR   = lv8_pipe_pkg::XZR
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rn,
   input  logic [REG_W-1:0] id_rm,
   input  logic             id_uses_rm,
   input  logic             ex_valid,
   input  logic             ex_memread,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             mem_redirect,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   input  logic             dbg_halt_req,
   input  logic             dbg_step,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             idex_write,
   output logic             exmem_write,
   output logic             memwb_write,
   output logic             idex_bubble,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic             flush_exmem,
   output logic             pc_sel_target,
   output logic             dbg_halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             load_use, memstall, redirect_hit;
   ctl_t             ctl;

   hazard_detect #(.REG_W(REG_W), .XZR(XZR)) u_hazard (
      .id_valid   (id_valid),
      .id_rn      (id_rn),
      .id_rm      (id_rm),
      .id_uses_rm (id_uses_rm),
      .ex_valid   (ex_valid),
      .ex_memread (ex_memread),
      .ex_rd      (ex_rd),
      .load_use   (load_use)
   );

   assign memstall = dmem_req & ~dmem_ready;

   always_comb begin
      ctl          = CTL_FREEZE;
      state_d      = state_q;
      redirect_hit = 1'b0;
      case (state_q)
         ST_RUN, ST_STEP: begin
            // A redirect squashes the dependent instruction, so the hazard is moot
            if (mem_redirect) begin
               ctl          = CTL_REDIRECT;
               redirect_hit = 1'b1;
            end else if (memstall) begin
               ctl = CTL_FREEZE;
            end else if (load_use) begin
               ctl = CTL_BUBBLE;
            end else begin
               ctl = CTL_GO;
            end
            if (memstall && !mem_redirect)
               state_d = ST_MEM_WAIT;
            else if (state_q == ST_STEP || dbg_halt_req)
               state_d = ST_HALTED;
            else
               state_d = ST_RUN;
         end
         ST_MEM_WAIT: begin
            // Halt requests wait here until the outstanding access retires
            if (dmem_ready) begin
               ctl     = CTL_GO;
               state_d = dbg_halt_req ? ST_HALTED : ST_RUN;
            end
         end
         default: begin
            if (dbg_step)
               state_d = ST_STEP;
            else if (!dbg_halt_req)
               state_d = ST_RUN;
         end
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!ctl.pc_write && state_q != ST_HALTED && !(&stall_cnt_q))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (redirect_hit && !(&flush_cnt_q))
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_RUN;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // While reset is held the pipeline is squashed and nothing advances
   assign pc_write      = reset_n & ctl.pc_write;
   assign ifid_write    = reset_n & ctl.ifid_write;
   assign idex_write    = reset_n & ctl.idex_write;
   assign exmem_write   = reset_n & ctl.exmem_write;
   assign memwb_write   = reset_n & ctl.memwb_write;
   assign idex_bubble   = reset_n & ctl.idex_bubble;
   assign flush_ifid    = ~reset_n | ctl.flush_ifid;
   assign flush_idex    = ~reset_n | ctl.flush_idex;
   assign flush_exmem   = ~reset_n | ctl.flush_exmem;
   assign pc_sel_target = reset_n & ctl.pc_sel_target;
   assign dbg_halted    = reset_n & (state_q == ST_HALTED);
   assign stall_cnt     = stall_cnt_q;
   assign flush_cnt     = flush_cnt_q;

endmodule
